// File: rtl/blink_link_pkg.sv
// Shared definitions for both ends of the IR blink link: state encoding,
// default code width and pulse timing, and helpers for sizing and frame length.
package blink_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } blink_state_e;

  localparam int BLINK_CODE_W     = 3;
  localparam int BLINK_ON_CYCLES  = 25_000_000;
  localparam int BLINK_OFF_CYCLES = 25_000_000;
  localparam int BLINK_GAP_CYCLES = 100_000_000;

  // Down-counter width that holds the largest reload value (longest phase minus one).
  function automatic int timerWidth(input int onCycles, input int offCycles,
                                    input int gapCycles);
    int maxCycles;
    maxCycles = onCycles;
    if (offCycles > maxCycles) maxCycles = offCycles;
    if (gapCycles > maxCycles) maxCycles = gapCycles;
    return (maxCycles <= 1) ? 1 : $clog2(maxCycles);
  endfunction

  function automatic int frameCycles(input int code, input int onCycles,
                                     input int offCycles, input int gapCycles);
    return (code + 1) * onCycles + code * offCycles + gapCycles;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that parks at zero; the zero flag marks the last
// cycle of whatever phase was loaded.
module blink_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/blink_code_tx.sv
// Transmit side of the IR blink link: sends a code as (code+1) timed pulses
// on the LED followed by a frame gap.
module blink_code_tx
  import blink_link_pkg::*;
#(
  parameter int CODE_W     = BLINK_CODE_W,
  parameter int ON_CYCLES  = BLINK_ON_CYCLES,
  parameter int OFF_CYCLES = BLINK_OFF_CYCLES,
  parameter int GAP_CYCLES = BLINK_GAP_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              blink_out,
  output logic [CODE_W-1:0] pulse_idx
);

  localparam int TIMER_W = timerWidth(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

  blink_state_e      r_state;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_pulseIdx;
  logic              r_blink;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;

  logic               w_timerZero;
  logic               w_timerLoad;
  logic [TIMER_W-1:0] w_timerLoadValue;
  logic               w_lastPulse;

  assign w_lastPulse = (r_pulseIdx == r_code);

  // Reload the timer on every phase change, mirroring the FSM transitions below.
  always_comb begin
    w_timerLoad      = 1'b0;
    w_timerLoadValue = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_timerLoad      = 1'b1;
          w_timerLoadValue = ON_LOAD;
        end
      end
      ST_ON: begin
        if (w_timerZero) begin
          w_timerLoad      = 1'b1;
          w_timerLoadValue = w_lastPulse ? GAP_LOAD : OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (w_timerZero) begin
          w_timerLoad      = 1'b1;
          w_timerLoadValue = ON_LOAD;
        end
      end
      default: begin
        w_timerLoad      = 1'b0;
        w_timerLoadValue = '0;
      end
    endcase
  end

  blink_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_timerLoad),
    .i_loadValue(w_timerLoadValue),
    .o_zero     (w_timerZero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_pulseIdx <= '0;
      r_blink    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_ON;
            r_code     <= code_in;
            r_pulseIdx <= '0;
            r_blink    <= 1'b1;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
          end
        end
        ST_ON: begin
          if (w_timerZero) begin
            r_state <= w_lastPulse ? ST_GAP : ST_OFF;
            r_blink <= 1'b0;
          end
        end
        ST_OFF: begin
          if (w_timerZero) begin
            r_state    <= ST_ON;
            r_pulseIdx <= r_pulseIdx + CODE_W'(1);
            r_blink    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_timerZero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_blink <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign blink_out = r_blink;
  assign pulse_idx = r_pulseIdx;

endmodule

// File: tb/tb_blink_code_tx.sv
// Self-checking bench for blink_code_tx with short timing (ON=4, OFF=3, GAP=10):
// table of single frames plus back-to-back and mid-frame reset sequences.
module tb_blink_code_tx;

  logic       clock;
  logic       reset;
  logic [2:0] code_in;
  logic       start;
  logic       ready;
  logic       busy;
  logic       done;
  logic       blink_out;
  logic [2:0] pulse_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] code;
    int         expPulses;
    int         expBusy;
    int         expDone;
    int         expMaxIdx;
  } vec_t;

  vec_t vecs[5];

  blink_code_tx #(
    .CODE_W    (3),
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .GAP_CYCLES(10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .code_in  (code_in),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .blink_out(blink_out),
    .pulse_idx(pulse_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Starts one frame and follows it to its done cycle, comparing blink_out and
  // pulse_idx each cycle against a waveform built from the code.
  task automatic applyStimulus(input logic [2:0] code, output int busyCycles,
                               output int pulses, output int doneCycle,
                               output int maxIdx, output int waveOk);
    bit   expBlink[$];
    int   expIdx[$];
    logic prevBlink;
    busyCycles = 0;
    pulses     = 0;
    doneCycle  = -1;
    maxIdx     = 0;
    waveOk     = 1;
    for (int p = 0; p <= int'(code); p++) begin
      repeat (4) begin expBlink.push_back(1'b1); expIdx.push_back(p); end
      if (p < int'(code)) begin
        repeat (3) begin expBlink.push_back(1'b0); expIdx.push_back(p); end
      end
    end
    repeat (10) begin expBlink.push_back(1'b0); expIdx.push_back(int'(code)); end
    start   = 1'b1;
    code_in = code;
    stepCycle();
    start     = 1'b0;
    code_in   = ~code;
    prevBlink = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        doneCycle = c;
        break;
      end
      if (busy) busyCycles++;
      if (blink_out && !prevBlink) pulses++;
      prevBlink = blink_out;
      if (int'(pulse_idx) > maxIdx) maxIdx = int'(pulse_idx);
      if (c > expBlink.size()) waveOk = 0;
      else if (blink_out !== expBlink[c-1] || int'(pulse_idx) != expIdx[c-1]) waveOk = 0;
      code_in = 3'(c);
      stepCycle();
    end
  endtask

  initial begin
    int busyCycles, pulses, doneCycle, maxIdx, waveOk;
    int busyA, busyB, pulsesB, gapRun, doneSeen, doneCount, highCount;
    logic prevBlink;

    vecs[0] = '{3'd0, 1, 14, 15, 0};
    vecs[1] = '{3'd1, 2, 21, 22, 1};
    vecs[2] = '{3'd2, 3, 28, 29, 2};
    vecs[3] = '{3'd5, 6, 49, 50, 5};
    vecs[4] = '{3'd7, 8, 63, 64, 7};

    reset   = 1'b1;
    start   = 1'b0;
    code_in = 3'd0;
    repeat (3) stepCycle();
    checkOutput("reset blink_out", int'(blink_out), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset ready", int'(ready), 1);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset pulse_idx", int'(pulse_idx), 0);
    reset = 1'b0;
    stepCycle();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].code, busyCycles, pulses, doneCycle, maxIdx, waveOk);
      checkOutput($sformatf("code%0d busy cycles", vecs[i].code), busyCycles, vecs[i].expBusy);
      checkOutput($sformatf("code%0d pulses", vecs[i].code), pulses, vecs[i].expPulses);
      checkOutput($sformatf("code%0d done cycle", vecs[i].code), doneCycle, vecs[i].expDone);
      checkOutput($sformatf("code%0d max pulse_idx", vecs[i].code), maxIdx, vecs[i].expMaxIdx);
      checkOutput($sformatf("code%0d waveform", vecs[i].code), waveOk, 1);
      checkOutput($sformatf("code%0d ready at done", vecs[i].code), int'(ready), 1);
      checkOutput($sformatf("code%0d busy at done", vecs[i].code), int'(busy), 0);
      stepCycle();
      checkOutput($sformatf("code%0d done one cycle", vecs[i].code), int'(done), 0);
      checkOutput($sformatf("code%0d idle ready", vecs[i].code), int'(ready), 1);
    end

    // Back-to-back: start held high, next code presented only in the done cycle.
    start   = 1'b1;
    code_in = 3'd1;
    stepCycle();
    busyA    = 0;
    doneSeen = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        doneSeen = 1;
        break;
      end
      if (busy) busyA++;
      code_in = 3'(c + 4);
      stepCycle();
    end
    checkOutput("b2b frame A done seen", doneSeen, 1);
    checkOutput("b2b frame A busy cycles", busyA, 21);
    checkOutput("b2b blink low in done cycle", int'(blink_out), 0);
    code_in = 3'd2;
    stepCycle();
    checkOutput("b2b frame B starts blink", int'(blink_out), 1);
    checkOutput("b2b frame B starts busy", int'(busy), 1);
    checkOutput("b2b frame B pulse_idx", int'(pulse_idx), 0);
    code_in   = 3'd6;
    busyB     = 0;
    pulsesB   = 0;
    gapRun    = 0;
    doneSeen  = 0;
    prevBlink = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        doneSeen = 1;
        break;
      end
      if (busy) busyB++;
      if (blink_out && !prevBlink) pulsesB++;
      prevBlink = blink_out;
      gapRun    = blink_out ? 0 : gapRun + 1;
      stepCycle();
    end
    start = 1'b0;
    checkOutput("b2b frame B done seen", doneSeen, 1);
    checkOutput("b2b frame B busy cycles", busyB, 28);
    checkOutput("b2b frame B pulses", pulsesB, 3);
    checkOutput("b2b frame B gap", gapRun, 10);
    stepCycle();
    checkOutput("b2b no restart after release", int'(busy), 0);

    // Reset during the second pulse of a code=3 frame.
    start   = 1'b1;
    code_in = 3'd3;
    stepCycle();
    start = 1'b0;
    repeat (8) stepCycle();
    checkOutput("abort second pulse blink", int'(blink_out), 1);
    checkOutput("abort second pulse idx", int'(pulse_idx), 1);
    reset = 1'b1;
    stepCycle();
    checkOutput("abort blink dropped", int'(blink_out), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort ready", int'(ready), 1);
    checkOutput("abort pulse_idx", int'(pulse_idx), 0);
    reset     = 1'b0;
    doneCount = 0;
    highCount = 0;
    for (int c = 0; c < 80; c++) begin
      if (done) doneCount++;
      if (blink_out) highCount++;
      stepCycle();
    end
    checkOutput("abort no done", doneCount, 0);
    checkOutput("abort stays dark", highCount, 0);
    checkOutput("abort idle ready", int'(ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
